dog_sprite_render: RTL and testbench

Scan-out consumer for the dog animation controller's outputs. It generates 640x480@60 VGA timing on `pixel_clk` and samples `ActionSel`/`DogPos_x`/`DogPos_y` once per frame. It composites a 64x64 sprite frame, chosen by `ActionSel`, over a flat background colour and drives registered sync, data-enable and 12-bit RGB to the display pins. It also returns a once-per-frame tick, so the controller can step its animation in lockstep with the display.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/dog_sprite_render_if.sv | 18 +
 rtl/dog_sprite_rom.sv | 11 +
 rtl/dog_sprite_render.sv | 90 +++++++++
 tb/tb_dog_sprite_render.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, pixel format and the sprite ROM contents.
package vga_pkg;
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int RGB_W  = 12;
  localparam int ACT_W  = 3;
  localparam int ADDR_W = 15;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hF0F;
  // Address-derived sprite art: each animation frame is the {dy,dx} index with
  // the frame number folded into the top bits, which places a few key-colour
  // (transparent) pixels in every frame.
  function automatic logic [RGB_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return a[11:0] ^ {a[14:12], 9'd0};
  endfunction
endpackage

// File: rtl/dog_sprite_render_if.sv
// dog_sprite_render_if: controller inputs (run, ActionSel, DogPos_x/y) and display outputs
// (hsync, vsync, de, rgb, frame_tick). slave = renderer side, master = controller/display side.
interface dog_sprite_render_if;
  import vga_pkg::*;
  logic             run;
  logic [ACT_W-1:0] ActionSel;
  logic [9:0]       DogPos_x;
  logic [8:0]       DogPos_y;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [RGB_W-1:0] rgb;
  logic             frame_tick;
  modport master (output run, ActionSel, DogPos_x, DogPos_y,
                  input  hsync, vsync, de, rgb, frame_tick);
  modport slave  (input  run, ActionSel, DogPos_x, DogPos_y,
                  output hsync, vsync, de, rgb, frame_tick);
endinterface

// File: rtl/dog_sprite_rom.sv
// dog_sprite_rom: synchronous sprite ROM, 1-cycle read latency.
// Ports: clk, i_addr {act,dy,dx} (15b), o_data RGB444 (12b).
module dog_sprite_rom
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [RGB_W-1:0]  o_data
);
  always_ff @(posedge clk) o_data <= rom_word(i_addr);
endmodule

// File: rtl/dog_sprite_render.sv
// dog_sprite_render: VGA timing generator compositing a 64x64 sprite over a flat background.
// Ports: pixel_clk, reset (async active-low), bus (slave modport: controller inputs, display outputs).
// Pipeline: S0 counters, S1 hit/address/flags + ROM read, S2 colour mux and output registers.
module dog_sprite_render
  import vga_pkg::*;
#(
  parameter int               SPRITE_W  = 64,
  parameter int               SPRITE_H  = 64,
  parameter logic [RGB_W-1:0] BG_COLOR  = 12'h036,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
  parameter int HVIS = H_VIS, HFP = H_FP, HSW = H_SYNC, HBP = H_BP,
  parameter int VVIS = V_VIS, VFP = V_FP, VSW = V_SYNC, VBP = V_BP
) (
  input  logic pixel_clk,
  input  logic reset,
  dog_sprite_render_if.slave bus
);
  localparam int HT = HVIS + HFP + HSW + HBP;
  localparam int VT = VVIS + VFP + VSW + VBP;
  logic [9:0]       r_h, r_v;
  logic             r_run;
  logic [ACT_W-1:0] r_act;
  logic [9:0]       r_px;
  logic [8:0]       r_py;
  logic             r_hit1, r_vis1, r_hs1, r_vs1, r_tick1;
  logic             r_hsync, r_vsync, r_de, r_tick;
  logic [RGB_W-1:0] r_rgb;
  logic [RGB_W-1:0] w_rom;
  logic [10:0]      w_dx, w_dy;
  logic             w_tick, w_vis, w_hit, w_hs, w_vs;
  assign w_tick = r_h == '0 && r_v == 10'(VVIS);
  // A negative difference wraps to >= 1024, so the range checks below also reject
  // pixels left of / above the sprite; the visibility term clips right/bottom.
  assign w_dx  = {1'b0, r_h} - {1'b0, r_px};
  assign w_dy  = {1'b0, r_v} - {2'b0, r_py};
  assign w_vis = r_h < 10'(HVIS) && r_v < 10'(VVIS);
  assign w_hit = r_run && w_vis && w_dx < 11'(SPRITE_W) && w_dy < 11'(SPRITE_H);
  assign w_hs  = !(r_h >= 10'(HVIS + HFP) && r_h < 10'(HVIS + HFP + HSW));
  assign w_vs  = !(r_v >= 10'(VVIS + VFP) && r_v < 10'(VVIS + VFP + VSW));
  dog_sprite_rom u_rom (
    .clk    (pixel_clk),
    .i_addr ({r_act, w_dy[5:0], w_dx[5:0]}),
    .o_data (w_rom)
  );
  always_ff @(posedge pixel_clk or negedge reset)
    if (!reset) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= r_h == 10'(HT - 1) ? '0 : r_h + 1'b1;
      if (r_h == 10'(HT - 1)) r_v <= r_v == 10'(VT - 1) ? '0 : r_v + 1'b1;
    end
  // Shadow copies change only at the start of vertical blank, so a frame never tears.
  always_ff @(posedge pixel_clk or negedge reset)
    if (!reset) begin
      r_run <= 1'b0;
      r_act <= '0;
      r_px  <= '0;
      r_py  <= '0;
    end else if (w_tick) begin
      r_run <= bus.run;
      r_act <= bus.ActionSel;
      r_px  <= bus.DogPos_x;
      r_py  <= bus.DogPos_y;
    end
  always_ff @(posedge pixel_clk or negedge reset)
    if (!reset) begin
      {r_hit1, r_vis1, r_tick1} <= '0;
      {r_hs1, r_vs1}            <= 2'b11;
      {r_de, r_tick}            <= '0;
      {r_hsync, r_vsync}        <= 2'b11;
      r_rgb                     <= '0;
    end else begin
      r_hit1  <= w_hit;
      r_vis1  <= w_vis;
      r_hs1   <= w_hs;
      r_vs1   <= w_vs;
      r_tick1 <= w_tick;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
      r_de    <= r_vis1;
      r_tick  <= r_tick1;
      r_rgb   <= !r_vis1 ? '0 : (r_hit1 && w_rom != KEY_COLOR) ? w_rom : BG_COLOR;
    end
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.de         = r_de;
  assign bus.rgb        = r_rgb;
  assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_dog_sprite_render.sv
// tb_dog_sprite_render: directed checks of a reduced-timing instance (sprite placement, latching,
// clipping, transparency, disable) and a full 640x480 instance (reset and line timing).
module tb_dog_sprite_render;
  localparam int HT = 176;
  localparam int VT = 86;
  localparam int FT = HT * VT;
  localparam logic [11:0] BG = 12'h036;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  int n = 0;
  int shl = 0, sde = 0, rhl = 0, rde = 0, rbg = 0;
  always #20 clk = ~clk;
  dog_sprite_render_if bus ();
  dog_sprite_render_if rbus ();
  dog_sprite_render #(.HVIS(160), .HFP(4), .HSW(8), .HBP(4),
                      .VVIS(80), .VFP(2), .VSW(2), .VBP(2))
    dut (.pixel_clk(clk), .reset(rst_n), .bus(bus));
  dog_sprite_render u_real (.pixel_clk(clk), .reset(rst_n), .bus(rbus));

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance until the small instance's pins show counter position (h,v) of frame f,
  // then park on the following falling edge for sampling.
  task automatic at(input int f, input int h, input int v);
    int t;
    t = f * FT + v * HT + h + 2;
    if (t <= n) begin
      errs++;
      $error("FAIL order: position %0d already passed at %0d", t, n);
    end else begin
      repeat (t - n) @(posedge clk);
      n = t;
      @(negedge clk);
    end
  endtask

  task automatic px(input string tag, input int f, input int h, input int v, input logic [11:0] exp);
    at(f, h, v);
    chk(tag, bus.rgb, exp);
  endtask

  initial begin
    bus.run = 1'b0; bus.ActionSel = '0; bus.DogPos_x = '0; bus.DogPos_y = '0;
    rbus.run = 1'b0; rbus.ActionSel = '0; rbus.DogPos_x = '0; rbus.DogPos_y = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk1("rst_hsync", bus.hsync, 1'b1);
    chk1("rst_vsync", bus.vsync, 1'b1);
    chk1("rst_de", bus.de, 1'b0);
    chk("rst_rgb", bus.rgb, 12'h000);
    chk1("rst_tick", bus.frame_tick, 1'b0);
    chk1("rst_real_hsync", rbus.hsync, 1'b1);
    chk("rst_real_rgb", rbus.rgb, 12'h000);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    chk1("de_edge1", bus.de, 1'b0);
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) chk1("de_edge2", bus.de, 1'b1);
      if (!bus.hsync) shl++;
      if (bus.de) sde++;
      if (!rbus.hsync) rhl++;
      if (rbus.de) rde++;
      if (rbus.rgb == BG) rbg++;
    end
    n = 1601;
    chk("real_hsync_low", 12'(rhl), 12'd192);
    chk("real_de_high", 12'(rde), 12'd1280);
    chk("real_bg_px", 12'(rbg), 12'd1280);
    chk("small_hsync_low", 12'(shl), 12'd72);
    chk("small_de_high", 12'(sde), 12'd1456);
    bus.run = 1'b1; bus.ActionSel = 3'd3; bus.DogPos_x = 10'd60; bus.DogPos_y = 9'd10;
    px("f0_shadow_off", 0, 60, 10, BG);
    at(0, 163, 12); chk1("hs_fp_end", bus.hsync, 1'b1);
    at(0, 164, 12); chk1("hs_start", bus.hsync, 1'b0);
    at(0, 171, 12); chk1("hs_end", bus.hsync, 1'b0);
    at(0, 172, 12); chk1("hs_bp", bus.hsync, 1'b1);
    at(0, 159, 13); chk1("de_last", bus.de, 1'b1);
    at(0, 160, 13); chk1("de_off", bus.de, 1'b0);
    chk("rgb_blank", bus.rgb, 12'h000);
    px("f0_bg", 0, 5, 20, BG);
    at(0, 0, 79); chk1("de_lastline", bus.de, 1'b1);
    at(0, 175, 79); chk1("tick_pre", bus.frame_tick, 1'b0);
    at(0, 0, 80); chk1("tick_on", bus.frame_tick, 1'b1);
    chk1("de_vblank", bus.de, 1'b0);
    at(0, 1, 80); chk1("tick_off", bus.frame_tick, 1'b0);
    at(0, 0, 81); chk1("vs_fp", bus.vsync, 1'b1);
    at(0, 0, 82); chk1("vs_start", bus.vsync, 1'b0);
    at(0, 175, 83); chk1("vs_end", bus.vsync, 1'b0);
    at(0, 0, 84); chk1("vs_bp", bus.vsync, 1'b1);
    px("f1_above", 1, 60, 9, BG);
    px("f1_left", 1, 59, 10, BG);
    px("f1_first", 1, 60, 10, 12'h600);
    px("f1_second", 1, 61, 10, 12'h601);
    bus.DogPos_x = 10'd100; bus.DogPos_y = 9'd20;
    px("f1_nomove", 1, 130, 40, BG);
    px("f1_key", 1, 75, 46, BG);
    px("f1_nokey", 1, 76, 46, 12'hF10);
    px("f1_last", 1, 123, 73, 12'h9FF);
    px("f1_right", 1, 124, 73, BG);
    px("f1_below", 1, 60, 74, BG);
    at(1, 0, 80); chk1("tick_period", bus.frame_tick, 1'b1);
    px("f2_oldgone", 2, 60, 10, BG);
    px("f2_first", 2, 100, 20, 12'h600);
    px("f2_nowrap_row", 2, 0, 21, BG);
    px("f2_inside", 2, 130, 40, 12'h31E);
    px("f2_lastcol", 2, 159, 40, 12'h33B);
    at(2, 160, 40);
    chk("f2_clip_rgb", bus.rgb, 12'h000);
    chk1("f2_clip_de", bus.de, 1'b0);
    bus.DogPos_x = 10'd120; bus.DogPos_y = 9'd60;
    px("f2_lastrow", 2, 100, 79, 12'h8C0);
    px("f3_top0", 3, 125, 0, BG);
    px("f3_top43", 3, 125, 43, BG);
    px("f3_left", 3, 119, 60, BG);
    px("f3_first", 3, 120, 60, 12'h600);
    px("f3_edge", 3, 159, 60, 12'h627);
    px("f3_col0", 3, 0, 61, BG);
    px("f3_corner", 3, 159, 79, 12'h2E7);
    bus.run = 1'b0; bus.DogPos_x = 10'd60; bus.DogPos_y = 9'd10;
    px("f4_off_a", 4, 60, 10, BG);
    px("f4_off_b", 4, 100, 40, BG);
    chk1("f4_de", bus.de, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_de", bus.de, 1'b0);
    chk("mid_rst_rgb", bus.rgb, 12'h000);
    chk1("mid_rst_hsync", bus.hsync, 1'b1);
    chk("mid_rst_real_rgb", rbus.rgb, 12'h000);
    #5;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("restart_de", bus.de, 1'b1);
    chk("restart_rgb", bus.rgb, BG);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
